exe_mem_req_unit: RTL and testbench
===================================

Name: exe_mem_req_unit

Overview:
Parametrised load/store request unit between the execute stage and the data cache. It takes memory ops from execute over a valid/ready handshake and generates size, byte strobes and lane-replicated store data. It detects address-alignment exceptions (ALE) and buffers legal requests in a QDEPTH-entry in-order queue, so execute no longer stalls directly on dcache addr_ok. The queue drains to the dcache with a valid/addr_ok handshake; a pipeline flush clears it.

Parameters:
DATA_W, 32, dcache data width in bits; 32 or 64.
ADDR_W, 32, virtual address width.
QDEPTH, 4, queue entries; power of 2, range 2..8.
ID_W, 4, op tag width, returned with request or exception.

Ports:
clk  in  1  clock
reset  in  1  reset
in_valid  in  1  execute presents mem op
in_ready  out  1  unit accepts op this cycle
in_op  in  1  0=load, 1=store
in_size  in  2  0=byte, 1=half, 2=word, 3=dword
in_addr  in  ADDR_W  effective address (ALU result)
in_wdata  in  DATA_W  store source (rkd value, low bits significant)
in_id  in  ID_W  op tag
flush  in  1  pipeline flush (excp/ertn/refetch/idle)
excp_valid  out  1  one-cycle ALE report
excp_badva  out  ADDR_W  faulting address
excp_id  out  ID_W  faulting op tag
req_valid  out  1  queue head valid
req_op  out  1  head op
req_size  out  3  {0,in_size}
req_addr  out  ADDR_W  head address
req_wstrb  out  DATA_W/8  byte strobes
req_wdata  out  DATA_W  lane-replicated store data
req_id  out  ID_W  head tag
req_addr_ok  in  1  dcache accepts head
q_count  out  $clog2(QDEPTH)+1  occupancy
q_empty  out  1  q_count==0

Behaviour:
- reset: synchronous, active-high; clock clk. Reset clears pointers and count. All outputs are 0 except q_empty=1 and in_ready=1 (the latter once reset is deasserted).
- in_ready = !full && !flush. Accept = in_valid && in_ready.
- A full queue stays not-ready even if a dequeue happens in the same cycle; there is no full-pass-through.
- ALE = (in_addr & ((1<<in_size)-1)) != 0, or (in_size==3 && DATA_W==32).
- An accepted ALE op is not enqueued. excp_valid pulses high the next cycle with excp_badva=in_addr and excp_id=in_id; otherwise excp_valid=0.
- A flush in the pulse-producing cycle suppresses the pulse.
- Legal accepted op: compute fields below, then enqueue.
  - OFF = in_addr[$clog2(DATA_W/8)-1:0].
  - Store strobe: ((1<<(1<<size))-1) << OFF, masked to DATA_W/8 bits.
  - Load strobe: 0.
  - Store data: low (8<<size) bits of in_wdata replicated across all lanes. Word on DATA_W=32 passes through unchanged.
- Latency: an op accepted in cycle N is visible on req_* in cycle N+1. There is no same-cycle bypass.
- req_valid = !q_empty. req_* are driven directly from the head entry and remain stable while req_valid && !req_addr_ok.
- Dequeue = req_valid && req_addr_ok; the queue advances one entry per cycle. Simultaneous enqueue and dequeue (not full) leaves q_count unchanged.
- Pointers are $clog2(QDEPTH)+1 bits wide and wrap naturally. full = MSBs differ && low bits equal.
- flush, synchronous:
  - Empties the queue next cycle (q_count=0, req_valid=0) and drops all pending entries.
  - A head handshaken in the flush cycle (req_addr_ok=1) counts as issued; it is not retracted.
  - No enqueue occurs in the flush cycle.
- reset mid-operation: all in-flight entries and any pending excp pulse are discarded. There is no req_valid glitch.
- req_wdata and req_wstrb for an empty queue are don't-care, but are driven 0 for verification determinism.

Decomposition:
- Shared package mem_req_pkg contains:
  - op encodings MEM_OP_LOAD/STORE and MEM_SZ_B/H/W/D;
  - the queue entry struct {op, size, addr, wstrb, wdata, id};
  - functions mem_strb(size, off) and mem_repl(size, data).
- One sub-module, mem_req_fifo: a generic synchronous FIFO with parameters WIDTH and DEPTH and ports push, pop, din, dout, full, empty, count.
- ALE, strobe and data formatting stay in the top module.

Test Plan:
- DATA_W=32, store byte, addr 0x1003, data 0xAABBCCDD -> next cycle req_valid=1, req_size=0, req_wstrb=4'b1000, req_wdata=0xDDDDDDDD.
- Load half at 0x1001 -> excp_valid=1 for exactly one cycle, excp_badva=0x1001, q_count stays 0, req_valid=0.
- req_addr_ok=0 with 5 back-to-back stores at 0x100/0x104/0x108/0x10C/0x110 -> 4 accepted, in_ready=0, q_count=4. Raising addr_ok issues 0x100..0x10C in order, one per cycle; the 5th is accepted the cycle after the first dequeue.
- q_count=3, flush=1 with req_addr_ok=1 in the same cycle -> head handshake counts; next cycle q_count=0, req_valid=0; no enqueue despite in_valid=1.
- DATA_W=64, store dword at 0x2008, data 0x1122334455667788 -> req_wstrb=8'hFF, req_wdata unchanged. DATA_W=32 with size=3 -> ALE pulse.
- Reset asserted with q_count=2 and a pending ALE -> next cycle all outputs 0, q_empty=1, no excp_valid.

Source files
------------

// File: rtl/mem_req_pkg.sv
// Shared encodings, queue entry layout and formatting helpers for the memory request unit.
package mem_req_pkg;

  localparam logic       MEM_OP_LOAD  = 1'b0;
  localparam logic       MEM_OP_STORE = 1'b1;

  localparam logic [1:0] MEM_SZ_B = 2'd0;
  localparam logic [1:0] MEM_SZ_H = 2'd1;
  localparam logic [1:0] MEM_SZ_W = 2'd2;
  localparam logic [1:0] MEM_SZ_D = 2'd3;

  // Entry fields are sized for the widest supported configuration (DATA_W<=64, ADDR_W<=64,
  // ID_W<=16); narrower instances zero-extend and the constant upper bits are trimmed.
  localparam int unsigned MEM_DATA_MAX = 64;
  localparam int unsigned MEM_STRB_MAX = MEM_DATA_MAX / 8;
  localparam int unsigned MEM_ADDR_MAX = 64;
  localparam int unsigned MEM_ID_MAX   = 16;

  typedef struct packed {
    logic                    op;
    logic [1:0]              size;
    logic [MEM_ADDR_MAX-1:0] addr;
    logic [MEM_STRB_MAX-1:0] wstrb;
    logic [MEM_DATA_MAX-1:0] wdata;
    logic [MEM_ID_MAX-1:0]   id;
  } mem_entry_t;

  // Byte-enable mask for an access of the given size starting at byte lane off.
  function automatic logic [MEM_STRB_MAX-1:0] mem_strb(input logic [1:0] size,
                                                       input logic [2:0] off);
    logic [MEM_STRB_MAX-1:0] base;
    case (size)
      MEM_SZ_B: base = 8'h01;
      MEM_SZ_H: base = 8'h03;
      MEM_SZ_W: base = 8'h0F;
      default:  base = 8'hFF;
    endcase
    return base << off;
  endfunction

  // Replicate the significant low bits of the store source across every lane.
  function automatic logic [MEM_DATA_MAX-1:0] mem_repl(input logic [1:0]              size,
                                                       input logic [MEM_DATA_MAX-1:0] data);
    logic [MEM_DATA_MAX-1:0] res;
    case (size)
      MEM_SZ_B: res = {8{data[7:0]}};
      MEM_SZ_H: res = {4{data[15:0]}};
      MEM_SZ_W: res = {2{data[31:0]}};
      default:  res = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_req_fifo.sv
// Generic synchronous in-order FIFO with wrap-bit pointers and a synchronous clear.
module mem_req_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       din_i,
  output logic [WIDTH-1:0]       dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH) + 1;
  localparam int unsigned IDX_W = PTR_W - 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (wptr_q[IDX_W] != rptr_q[IDX_W]) &&
                   (wptr_q[IDX_W-1:0] == rptr_q[IDX_W-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign count_o = wptr_q - rptr_q;
  assign do_push = push_i && !full_o && !clr_i;
  assign do_pop  = pop_i && !empty_o;

  // Empty FIFO presents zeros so downstream sees deterministic data.
  assign dout_o = empty_o ? '0 : mem_q[rptr_q[IDX_W-1:0]];

  // Pointer next-state; clear wins over push/pop.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (clr_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
    end
  end

  // Pointer registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage array; contents are only observable through valid pointers, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[IDX_W-1:0]] <= din_i;
  end

endmodule

// File: rtl/exe_mem_req_unit.sv
// Load/store request unit: formats execute-stage memory ops, raises alignment exceptions
// and queues legal requests in order towards the data cache.
module exe_mem_req_unit
  import mem_req_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned QDEPTH = 4,
  parameter int unsigned ID_W   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic                    in_op_i,
  input  logic [1:0]              in_size_i,
  input  logic [ADDR_W-1:0]       in_addr_i,
  input  logic [DATA_W-1:0]       in_wdata_i,
  input  logic [ID_W-1:0]         in_id_i,
  input  logic                    flush_i,
  output logic                    excp_valid_o,
  output logic [ADDR_W-1:0]       excp_badva_o,
  output logic [ID_W-1:0]         excp_id_o,
  output logic                    req_valid_o,
  output logic                    req_op_o,
  output logic [2:0]              req_size_o,
  output logic [ADDR_W-1:0]       req_addr_o,
  output logic [DATA_W/8-1:0]     req_wstrb_o,
  output logic [DATA_W-1:0]       req_wdata_o,
  output logic [ID_W-1:0]         req_id_o,
  input  logic                    req_addr_ok_i,
  output logic [$clog2(QDEPTH):0] q_count_o,
  output logic                    q_empty_o
);

  localparam int unsigned STRB_W  = DATA_W / 8;
  localparam int unsigned OFF_W   = $clog2(STRB_W);
  localparam int unsigned CNT_W   = $clog2(QDEPTH) + 1;
  localparam int unsigned ENTRY_W = $bits(mem_entry_t);

  logic                    accept;
  logic                    ale;
  logic [2:0]              addr_lo;
  logic [2:0]              off;
  logic [MEM_STRB_MAX-1:0] strb_full;
  logic [MEM_DATA_MAX-1:0] repl_full;
  mem_entry_t              new_entry;
  mem_entry_t              head;
  logic                    full;
  logic                    empty;
  logic [CNT_W-1:0]        count;
  logic                    push;
  logic                    pop;

  logic                    excp_valid_q, excp_valid_d;
  logic [ADDR_W-1:0]       excp_badva_q, excp_badva_d;
  logic [ID_W-1:0]         excp_id_q, excp_id_d;

  logic                    unused_fmt;
  logic                    unused_head;

  // No full pass-through: a full queue refuses new ops even while it drains.
  assign in_ready_o = !full && !flush_i && !reset;
  assign accept     = in_valid_i && in_ready_o;

  assign addr_lo = in_addr_i[2:0];
  assign off     = 3'(in_addr_i[OFF_W-1:0]);

  // Alignment check; a dword can never be issued on a 32-bit data path.
  always_comb begin
    ale = 1'b0;
    case (in_size_i)
      MEM_SZ_B: ale = 1'b0;
      MEM_SZ_H: ale = addr_lo[0];
      MEM_SZ_W: ale = |addr_lo[1:0];
      default:  ale = (DATA_W == 32) || (|addr_lo);
    endcase
  end

  assign strb_full = mem_strb(in_size_i, off);
  assign repl_full = mem_repl(in_size_i, MEM_DATA_MAX'(in_wdata_i));

  // Build the queue entry; loads carry zero strobe and zero data.
  always_comb begin
    new_entry      = '0;
    new_entry.op   = in_op_i;
    new_entry.size = in_size_i;
    new_entry.addr = MEM_ADDR_MAX'(in_addr_i);
    new_entry.id   = MEM_ID_MAX'(in_id_i);
    if (in_op_i == MEM_OP_STORE) begin
      new_entry.wstrb = MEM_STRB_MAX'(strb_full[STRB_W-1:0]);
      new_entry.wdata = MEM_DATA_MAX'(repl_full[DATA_W-1:0]);
    end
  end

  assign push = accept && !ale;
  assign pop  = req_valid_o && req_addr_ok_i;

  mem_req_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (flush_i),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (new_entry),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign req_valid_o = !empty;
  assign req_op_o    = head.op;
  assign req_size_o  = {1'b0, head.size};
  assign req_addr_o  = head.addr[ADDR_W-1:0];
  assign req_wstrb_o = head.wstrb[STRB_W-1:0];
  assign req_wdata_o = head.wdata[DATA_W-1:0];
  assign req_id_o    = head.id[ID_W-1:0];
  assign q_count_o   = count;
  assign q_empty_o   = empty;

  // Exception next-state: capture the faulting op only when an ALE op is accepted.
  always_comb begin
    excp_valid_d = accept && ale;
    excp_badva_d = '0;
    excp_id_d    = '0;
    if (accept && ale) begin
      excp_badva_d = in_addr_i;
      excp_id_d    = in_id_i;
    end
  end

  // Exception pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      excp_valid_q <= 1'b0;
      excp_badva_q <= '0;
      excp_id_q    <= '0;
    end else begin
      excp_valid_q <= excp_valid_d;
      excp_badva_q <= excp_badva_d;
      excp_id_q    <= excp_id_d;
    end
  end

  // A flush arriving while the pulse is due squashes it: the faulting op is younger.
  assign excp_valid_o = excp_valid_q && !flush_i;
  assign excp_badva_o = excp_badva_q;
  assign excp_id_o    = excp_id_q;

  // Upper bits of the max-width helpers/entry are unused in narrow configurations.
  assign unused_fmt  = ^{strb_full, repl_full};
  assign unused_head = ^{head.addr, head.wstrb, head.wdata, head.id};

endmodule

// File: tb/tb_exe_mem_req_unit.sv
// Bench for exe_mem_req_unit: vector table, multi-cycle corner sequences and a randomized
// run against a queue-based reference model. Instantiates 32- and 64-bit data variants.
module tb_exe_mem_req_unit;

  localparam int unsigned QD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        in_valid, in_op, flush, req_addr_ok;
  logic [1:0]  in_size;
  logic [31:0] in_addr;
  logic [63:0] in_wdata;
  logic [3:0]  in_id;

  logic        a_in_ready, a_excp_valid, a_req_valid, a_req_op, a_q_empty;
  logic [31:0] a_excp_badva, a_req_addr, a_req_wdata;
  logic [3:0]  a_excp_id, a_req_wstrb, a_req_id;
  logic [2:0]  a_req_size, a_q_count;

  logic        b_in_ready, b_excp_valid, b_req_valid, b_req_op, b_q_empty;
  logic [31:0] b_excp_badva, b_req_addr;
  logic [63:0] b_req_wdata;
  logic [7:0]  b_req_wstrb;
  logic [3:0]  b_excp_id, b_req_id;
  logic [2:0]  b_req_size, b_q_count;

  exe_mem_req_unit #(.DATA_W(32), .ADDR_W(32), .QDEPTH(QD), .ID_W(4)) dut32 (
    .clk(clk), .reset(reset), .in_valid_i(in_valid), .in_ready_o(a_in_ready),
    .in_op_i(in_op), .in_size_i(in_size), .in_addr_i(in_addr), .in_wdata_i(in_wdata[31:0]),
    .in_id_i(in_id), .flush_i(flush), .excp_valid_o(a_excp_valid),
    .excp_badva_o(a_excp_badva), .excp_id_o(a_excp_id), .req_valid_o(a_req_valid),
    .req_op_o(a_req_op), .req_size_o(a_req_size), .req_addr_o(a_req_addr),
    .req_wstrb_o(a_req_wstrb), .req_wdata_o(a_req_wdata), .req_id_o(a_req_id),
    .req_addr_ok_i(req_addr_ok), .q_count_o(a_q_count), .q_empty_o(a_q_empty)
  );

  exe_mem_req_unit #(.DATA_W(64), .ADDR_W(32), .QDEPTH(QD), .ID_W(4)) dut64 (
    .clk(clk), .reset(reset), .in_valid_i(in_valid), .in_ready_o(b_in_ready),
    .in_op_i(in_op), .in_size_i(in_size), .in_addr_i(in_addr), .in_wdata_i(in_wdata),
    .in_id_i(in_id), .flush_i(flush), .excp_valid_o(b_excp_valid),
    .excp_badva_o(b_excp_badva), .excp_id_o(b_excp_id), .req_valid_o(b_req_valid),
    .req_op_o(b_req_op), .req_size_o(b_req_size), .req_addr_o(b_req_addr),
    .req_wstrb_o(b_req_wstrb), .req_wdata_o(b_req_wdata), .req_id_o(b_req_id),
    .req_addr_ok_i(req_addr_ok), .q_count_o(b_q_count), .q_empty_o(b_q_empty)
  );

  int total = 0;
  int bad   = 0;

  // Output view of whichever DUT a vector targets.
  bit          sel_wide = 1'b0;
  logic [63:0] s_ev, s_badva, s_eid, s_rv, s_op, s_size, s_addr, s_strb, s_data, s_id, s_cnt;

  always_comb begin
    if (sel_wide) begin
      s_ev = 64'(b_excp_valid); s_badva = 64'(b_excp_badva); s_eid = 64'(b_excp_id);
      s_rv = 64'(b_req_valid);  s_op = 64'(b_req_op);        s_size = 64'(b_req_size);
      s_addr = 64'(b_req_addr); s_strb = 64'(b_req_wstrb);   s_data = b_req_wdata;
      s_id = 64'(b_req_id);     s_cnt = 64'(b_q_count);
    end else begin
      s_ev = 64'(a_excp_valid); s_badva = 64'(a_excp_badva); s_eid = 64'(a_excp_id);
      s_rv = 64'(a_req_valid);  s_op = 64'(a_req_op);        s_size = 64'(a_req_size);
      s_addr = 64'(a_req_addr); s_strb = 64'(a_req_wstrb);   s_data = 64'(a_req_wdata);
      s_id = 64'(a_req_id);     s_cnt = 64'(a_q_count);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0; in_op = 1'b0; in_size = 2'd0; in_addr = '0; in_wdata = '0; in_id = '0;
    flush = 1'b0; req_addr_ok = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Reference formatting derived from the access rules with plain arithmetic.
  function automatic void model_fields(input logic op, input logic [1:0] size,
                                       input logic [31:0] addr, input logic [63:0] wd,
                                       input int dw, output bit ale,
                                       output logic [7:0] strb, output logic [63:0] data);
    int nb;
    int lanes;
    longint unsigned mask;
    nb    = 1 << size;
    lanes = dw / 8;
    ale   = ((addr % nb) != 0) || (size == 2'd3 && dw == 32);
    strb  = '0;
    data  = '0;
    if (op) begin
      strb = 8'((((1 << nb) - 1) << (addr % lanes)) & ((1 << lanes) - 1));
      mask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 1);
      for (int i = 0; i < lanes / nb; i++) data |= (wd & mask) << (8 * nb * i);
    end
  endfunction

  typedef struct {
    bit          wide;
    logic        op;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [3:0]  id;
    bit          ale;
    logic [7:0]  strb;
    logic [63:0] data;
  } vec_t;

  vec_t vecs[$];

  task automatic apply_vec(input vec_t v, input int k);
    sel_wide = v.wide;
    idle();
    in_valid = 1'b1; in_op = v.op; in_size = v.size; in_addr = v.addr;
    in_wdata = v.wdata; in_id = v.id;
    tick();
    idle();
    @(negedge clk);
    if (v.ale) begin
      chk($sformatf("v%0d_excp_valid", k), s_ev, 64'd1);
      chk($sformatf("v%0d_excp_badva", k), s_badva, 64'(v.addr));
      chk($sformatf("v%0d_excp_id", k), s_eid, 64'(v.id));
      chk($sformatf("v%0d_req_valid", k), s_rv, 64'd0);
      chk($sformatf("v%0d_q_count", k), s_cnt, 64'd0);
    end else begin
      chk($sformatf("v%0d_excp_valid", k), s_ev, 64'd0);
      chk($sformatf("v%0d_req_valid", k), s_rv, 64'd1);
      chk($sformatf("v%0d_req_op", k), s_op, 64'(v.op));
      chk($sformatf("v%0d_req_size", k), s_size, 64'(v.size));
      chk($sformatf("v%0d_req_addr", k), s_addr, 64'(v.addr));
      chk($sformatf("v%0d_req_wstrb", k), s_strb, 64'(v.strb));
      chk($sformatf("v%0d_req_wdata", k), s_data, v.data);
      chk($sformatf("v%0d_req_id", k), s_id, 64'(v.id));
      chk($sformatf("v%0d_q_count", k), s_cnt, 64'd1);
    end
    tick();
    req_addr_ok = 1'b1;
    @(negedge clk);
    chk($sformatf("v%0d_excp_once", k), s_ev, 64'd0);
    tick();
    idle();
    @(negedge clk);
    chk($sformatf("v%0d_drained_cnt", k), s_cnt, 64'd0);
    chk($sformatf("v%0d_drained_strb", k), s_strb, 64'd0);
    tick();
  endtask

  typedef struct {
    logic        op;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
    logic [3:0]  id;
  } ent_t;

  ent_t        mq[$];
  bit          pend;
  logic [31:0] pbad;
  logic [3:0]  pid;

  initial begin
    reset = 1'b1;
    do_reset();

    // Reset state, both widths.
    @(negedge clk);
    chk("rst_in_ready", a_in_ready, 64'd1);
    chk("rst_q_empty", a_q_empty, 64'd1);
    chk("rst_q_count", a_q_count, 64'd0);
    chk("rst_req_valid", a_req_valid, 64'd0);
    chk("rst_excp_valid", a_excp_valid, 64'd0);
    chk("rst_req_wdata", a_req_wdata, 64'd0);
    chk("rst64_q_empty", b_q_empty, 64'd1);
    chk("rst64_in_ready", b_in_ready, 64'd1);
    tick();

    vecs.push_back('{0, 1, 2'd0, 32'h1003, 64'hAABBCCDD, 4'd1, 0, 8'h08, 64'hDDDDDDDD});
    vecs.push_back('{0, 0, 2'd1, 32'h1001, 64'h0, 4'd2, 1, 8'h00, 64'h0});
    vecs.push_back('{0, 1, 2'd1, 32'h1002, 64'h12345678, 4'd3, 0, 8'h0C, 64'h56785678});
    vecs.push_back('{0, 1, 2'd2, 32'h1000, 64'hCAFEF00D, 4'd4, 0, 8'h0F, 64'hCAFEF00D});
    vecs.push_back('{0, 0, 2'd2, 32'h1004, 64'h9999, 4'd5, 0, 8'h00, 64'h0});
    vecs.push_back('{0, 1, 2'd2, 32'h1006, 64'h1, 4'd6, 1, 8'h00, 64'h0});
    vecs.push_back('{0, 1, 2'd3, 32'h1000, 64'h1, 4'd7, 1, 8'h00, 64'h0});
    vecs.push_back('{0, 1, 2'd0, 32'h1000, 64'h55, 4'd8, 0, 8'h01, 64'h55555555});
    vecs.push_back('{0, 0, 2'd0, 32'h1FFF, 64'h0, 4'd9, 0, 8'h00, 64'h0});
    vecs.push_back('{0, 1, 2'd1, 32'h1001, 64'h7, 4'd10, 1, 8'h00, 64'h0});
    vecs.push_back('{1, 1, 2'd3, 32'h2008, 64'h1122334455667788, 4'd11, 0, 8'hFF,
                     64'h1122334455667788});
    vecs.push_back('{1, 1, 2'd3, 32'h2004, 64'h1, 4'd12, 1, 8'h00, 64'h0});
    vecs.push_back('{1, 1, 2'd2, 32'h2004, 64'hDEADBEEF, 4'd13, 0, 8'hF0,
                     64'hDEADBEEFDEADBEEF});
    vecs.push_back('{1, 1, 2'd0, 32'h2005, 64'hAB, 4'd14, 0, 8'h20, 64'hABABABABABABABAB});
    vecs.push_back('{1, 1, 2'd1, 32'h2006, 64'h1234, 4'd15, 0, 8'hC0, 64'h1234123412341234});
    foreach (vecs[k]) apply_vec(vecs[k], k);
    sel_wide = 1'b0;

    // Backpressure: four stores fill the queue, the fifth waits for a slot.
    idle();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_op = 1'b1; in_size = 2'd2;
      in_addr = 32'h100 + 32'(4 * i); in_wdata = 64'(i); in_id = 4'(i);
      @(negedge clk);
      if (i < 4) begin
        chk($sformatf("bp_ready%0d", i), a_in_ready, 64'd1);
      end else begin
        chk("bp_full_ready", a_in_ready, 64'd0);
        chk("bp_full_count", a_q_count, 64'd4);
      end
      tick();
    end
    req_addr_ok = 1'b1;
    @(negedge clk);
    chk("bp_head0", a_req_addr, 64'h100);
    chk("bp_no_passthru", a_in_ready, 64'd0);
    tick();
    @(negedge clk);
    chk("bp_head1", a_req_addr, 64'h104);
    chk("bp_count1", a_q_count, 64'd3);
    chk("bp_ready_again", a_in_ready, 64'd1);
    tick();
    in_valid = 1'b0;
    for (int i = 2; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_head%0d", i), a_req_addr, 64'h100 + 64'(4 * i));
      chk($sformatf("bp_id%0d", i), a_req_id, 64'(i));
      chk($sformatf("bp_count%0d", i), a_q_count, 64'(5 - i));
      tick();
    end
    idle();
    @(negedge clk);
    chk("bp_empty_valid", a_req_valid, 64'd0);
    chk("bp_empty_count", a_q_count, 64'd0);
    tick();

    // Flush with a concurrent head handshake and a pending enqueue.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_op = 1'b1; in_size = 2'd2; in_addr = 32'h200 + 32'(4 * i);
      tick();
    end
    in_addr = 32'h220; flush = 1'b1; req_addr_ok = 1'b1;
    @(negedge clk);
    chk("fl_ready", a_in_ready, 64'd0);
    chk("fl_count_pre", a_q_count, 64'd3);
    chk("fl_head", a_req_addr, 64'h200);
    tick();
    idle();
    @(negedge clk);
    chk("fl_count", a_q_count, 64'd0);
    chk("fl_valid", a_req_valid, 64'd0);
    chk("fl_empty", a_q_empty, 64'd1);
    tick();
    @(negedge clk);
    chk("fl_no_late_enq", a_q_count, 64'd0);
    tick();

    // Reset while entries are queued and an exception pulse is in flight.
    in_valid = 1'b1; in_op = 1'b1; in_size = 2'd2; in_addr = 32'h300; tick();
    in_addr = 32'h304; tick();
    in_op = 1'b0; in_size = 2'd1; in_addr = 32'h301; in_id = 4'd7; tick();
    idle();
    reset = 1'b1;
    @(negedge clk);
    chk("rm_pre_count", a_q_count, 64'd2);
    chk("rm_pre_excp", a_excp_valid, 64'd1);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rm_excp", a_excp_valid, 64'd0);
    chk("rm_badva", a_excp_badva, 64'd0);
    chk("rm_valid", a_req_valid, 64'd0);
    chk("rm_count", a_q_count, 64'd0);
    chk("rm_empty", a_q_empty, 64'd1);
    chk("rm_wstrb", a_req_wstrb, 64'd0);
    chk("rm_wdata", a_req_wdata, 64'd0);
    chk("rm_ready", a_in_ready, 64'd1);
    tick();
    @(negedge clk);
    chk("rm_excp_later", a_excp_valid, 64'd0);
    chk("rm_valid_later", a_req_valid, 64'd0);
    tick();

    // Randomized traffic on the 32-bit unit against the queue model.
    do_reset();
    mq.delete();
    pend = 1'b0; pbad = '0; pid = '0;
    for (int c = 0; c < 1500; c++) begin
      bit          exp_ready, acc, ale;
      logic [7:0]  strb;
      logic [63:0] data;
      ent_t        h;
      in_valid    = ($urandom_range(0, 9) < 7);
      in_op       = 1'($urandom);
      in_size     = 2'($urandom_range(0, 3));
      in_addr     = $urandom;
      if ($urandom_range(0, 1) == 1) in_addr = in_addr & ~((32'd1 << in_size) - 32'd1);
      in_wdata    = {$urandom, $urandom};
      in_id       = 4'($urandom);
      req_addr_ok = ($urandom_range(0, 9) < 6);
      flush       = ($urandom_range(0, 19) == 0);
      @(negedge clk);
      exp_ready = (mq.size() < QD) && !flush;
      chk("rnd_ready", a_in_ready, 64'(exp_ready));
      chk("rnd_count", a_q_count, 64'(mq.size()));
      chk("rnd_valid", a_req_valid, 64'(mq.size() != 0));
      chk("rnd_excp_valid", a_excp_valid, 64'(pend && !flush));
      if (pend && !flush) begin
        chk("rnd_excp_badva", a_excp_badva, 64'(pbad));
        chk("rnd_excp_id", a_excp_id, 64'(pid));
      end
      if (mq.size() != 0) begin
        h = mq[0];
        chk("rnd_op", a_req_op, 64'(h.op));
        chk("rnd_size", a_req_size, 64'(h.size));
        chk("rnd_addr", a_req_addr, 64'(h.addr));
        chk("rnd_wstrb", a_req_wstrb, 64'(h.strb));
        chk("rnd_wdata", a_req_wdata, 64'(h.data));
        chk("rnd_id", a_req_id, 64'(h.id));
      end
      acc = in_valid && exp_ready;
      model_fields(in_op, in_size, in_addr, {32'd0, in_wdata[31:0]}, 32, ale, strb, data);
      if (mq.size() != 0 && req_addr_ok) void'(mq.pop_front());
      if (flush) mq.delete();
      else if (acc && !ale) mq.push_back('{in_op, in_size, in_addr, strb[3:0], data[31:0], in_id});
      pend = acc && ale;
      pbad = in_addr;
      pid  = in_id;
      tick();
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
